bool_bist_checker: RTL and testbench
====================================

// Module: bool_bist_checker
// PURPOSE
//  In-circuit exhaustive tester for a small combinational boolean block (N_IN inputs, 1 output).
//  Drives every input vector 0..2**N_IN-1, samples the DUT response and compares it with an expected truth table.
//  Reports pass/fail, mismatch count, first failing vector and the full captured response word.
//  Sits between the board/SoC control logic and a boolean_expression_* instance.
// PARAMETERS
//  N_IN      4         number of DUT inputs; vector index bit N_IN-1 drives input A (MSB)
//  EXPECTED  16'hF888  expected truth table, width 2**N_IN; bit i = expected Y for vector i
//  SETTLE    0         extra hold cycles per vector before sampling (0 = sample at end of first cycle)
// PORTS
//  clk             in   1          rising-edge clock
//  rst_n           in   1          asynchronous, active-low reset
//  start           in   1          level/pulse; sampled only in IDLE or DONE
//  abcd            out  N_IN       stimulus to DUT inputs {A,B,C,D}, registered
//  y               in   1          DUT response
//  busy            out  1          high while the sweep is running
//  done            out  1          high from sweep completion until next start or reset
//  pass            out  1          1 when done && err_count==0; 0 otherwise
//  err_count       out  N_IN+1     number of mismatching vectors (0..2**N_IN)
//  first_fail_idx  out  N_IN       index of the first mismatching vector; 0 if none
//  first_fail_vld  out  1          first_fail_idx holds a valid index
//  resp            out  2**N_IN    captured responses; bit i = y sampled for vector i
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; abcd, busy, done, pass, err_count, first_fail_*, resp all 0; counters 0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: abcd=0. start=1 at an edge -> RUN, idx=0, settle cnt=0, err_count/first_fail_*/resp cleared.
//   RUN : busy=1, abcd=idx. Each vector is held exactly SETTLE+1 cycles.
//         At the edge where cnt==SETTLE: resp[idx]<=y; if y!=EXPECTED[idx] then err_count+=1,
//         and if !first_fail_vld then first_fail_idx<=idx, first_fail_vld<=1. Then idx+=1, cnt=0.
//         After sampling idx==2**N_IN-1 -> DONE (no wrap of idx is ever used as a vector).
//         start is ignored while in RUN.
//   DONE: busy=0, done=1, abcd=0, pass=(err_count==0). Results held stable.
//         start=1 -> same transition as from IDLE (done drops the same edge, results cleared).
//  Latency: done rises 2**N_IN*(SETTLE+1) clock edges after the edge that accepted start.
//  Widths: err_count is N_IN+1 bits so that all vectors failing (2**N_IN) does not overflow.
//  y is treated as synchronous to clk (DUT is combinational off abcd); no synchroniser inside.
//  Reset mid-RUN: immediate abort, all outputs zero, no partial results kept.
//  start held high continuously: a new sweep begins on the edge after each DONE is entered.
// TESTING (defaults unless stated; ref model Y=A&B | C&D, truth table 16'hF888)
//  1 ideal model, start pulse -> abcd steps 0..15 one per cycle; done at +16 edges; pass=1, err_count=0, resp=16'hF888.
//  2 y stuck-at-0 -> err_count=7, first_fail_idx=3, first_fail_vld=1, pass=0, resp=16'h0000.
//  3 SETTLE=2, ideal model -> each abcd value held exactly 3 cycles; done at +48 edges; pass=1.
//  4 model with vector 15 inverted -> err_count=1, first_fail_idx=15, resp=16'h7888, pass=0.
//  5 start re-pulsed at idx=6 -> ignored (abcd continues 7,8...); start in DONE -> done=0, err_count=0, new 16-cycle sweep.
//  6 rst_n low asynchronously at idx=5 (mid-cycle) -> busy/abcd/resp=0 before next edge; after release, start -> full clean sweep, pass=1.

Source files
------------

// File: rtl/bool_bist_checker.sv
// rtl/bool_bist_checker.sv - exhaustive in-circuit tester for a small combinational boolean block
//
// Sweeps every input vector 0..2**N_IN-1 onto abcd and holds each for SETTLE+1
// cycles. y is sampled on the last cycle of each vector and compared with
// EXPECTED. The results stay stable in DONE until the next start or reset.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           begins a sweep; sampled only in IDLE or DONE
//   abcd            registered stimulus to the DUT; MSB drives input A
//   y               DUT response; assumed synchronous to clk
//   busy            high while the sweep is running
//   done            high from sweep completion until the next start or reset
//   pass            done with zero mismatches
//   err_count       number of mismatching vectors (0..2**N_IN)
//   first_fail_idx  first mismatching vector index; 0 if none
//   first_fail_vld  first_fail_idx is meaningful
//   resp            captured responses; bit i is y sampled for vector i

module bool_bist_checker #(
    parameter int                  N_IN     = 4,
    parameter logic [2**N_IN-1:0]  EXPECTED = 16'hF888,
    parameter int                  SETTLE   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      abcd,
    input  logic                 y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 first_fail_vld,
    output logic [2**N_IN-1:0]   resp
);

    // A counter of at least one bit keeps SETTLE=0 legal.
    localparam int              CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    // abcd doubles as the vector index while running. It is forced to 0
    // outside RUN, and start reloads it to 0, so no separate idx register is
    // needed.
    assign mismatch = (y != EXPECTED[abcd]);
    assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            abcd           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            resp           <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        cnt            <= '0;
                        abcd           <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                        resp           <= '0;
                    end
                end

                S_RUN: begin
                    if (cnt == SETTLE_C) begin
                        // Last hold cycle of this vector, so y has settled.
                        resp[abcd] <= y;
                        err_count  <= err_next;
                        if (mismatch && !first_fail_vld) begin
                            first_fail_idx <= abcd;
                            first_fail_vld <= 1'b1;
                        end
                        cnt <= '0;
                        if (abcd == LAST_IDX) begin
                            // Stop before the index wraps, so vector 0 is
                            // never applied twice in one sweep.
                            state <= S_DONE;
                            abcd  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            abcd <= abcd + N_IN'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bool_bist_checker.sv
// tb/tb_bool_bist_checker.sv - scoreboard testbench for bool_bist_checker

module tb_bool_bist_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [3:0]  abcd_a, abcd_b;
    logic        y_a, y_b;
    logic        busy_a, done_a, pass_a, ffv_a;
    logic        busy_b, done_b, pass_b, ffv_b;
    logic [4:0]  err_a, err_b;
    logic [3:0]  ffi_a, ffi_b;
    logic [15:0] resp_a, resp_b;

    int errors = 0;
    int checks = 0;
    int mode   = 0;

    typedef struct {
        logic [4:0]  err;
        logic [3:0]  ffi;
        logic        ffv;
        logic [15:0] resp;
        logic        pass;
    } res_t;

    int   exp_abcd[$];
    res_t exp_res[$];

    always #5 clk = ~clk;

    function automatic logic ref_y(logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    // Mode 0 is the ideal model, mode 1 is y stuck at 0, and mode 2 inverts vector 15.
    function automatic logic dut_y(logic [3:0] v, int m);
        if (m == 1) return 1'b0;
        if (m == 2 && v == 4'd15) return ~ref_y(v);
        return ref_y(v);
    endfunction

    always_comb y_a = dut_y(abcd_a, mode);
    always_comb y_b = dut_y(abcd_b, 0);

    bool_bist_checker #(.N_IN(4), .EXPECTED(16'hF888), .SETTLE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abcd(abcd_a), .y(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_idx(ffi_a), .first_fail_vld(ffv_a), .resp(resp_a)
    );

    bool_bist_checker #(.N_IN(4), .EXPECTED(16'hF888), .SETTLE(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abcd(abcd_b), .y(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_idx(ffi_b), .first_fail_vld(ffv_b), .resp(resp_b)
    );

    task automatic push_sweep(input int m, input int hold);
        res_t r;
        r.err = '0; r.ffi = '0; r.ffv = 1'b0; r.resp = '0;
        for (int v = 0; v < 16; v++) begin
            logic yv;
            yv = dut_y(4'(v), m);
            for (int h = 0; h < hold; h++) exp_abcd.push_back(v);
            r.resp[v] = yv;
            if (yv != ref_y(4'(v))) begin
                r.err = r.err + 5'd1;
                if (!r.ffv) begin
                    r.ffi = 4'(v);
                    r.ffv = 1'b1;
                end
            end
        end
        r.pass = (r.err == 5'd0);
        exp_res.push_back(r);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({abcd_a, busy_a, done_a, pass_a, err_a, ffi_a, ffv_a, resp_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h required 0",
                     {abcd_a, busy_a, done_a, pass_a, err_a, ffi_a, ffv_a, resp_a});
        end
        checks++;
        if ({abcd_b, busy_b, done_b, pass_b, err_b, ffi_b, ffv_b, resp_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h required 0",
                     {abcd_b, busy_b, done_b, pass_b, err_b, ffi_b, ffv_b, resp_b});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sweep_patterns;
        for (int m = 0; m < 3; m++) begin
            res_t r;
            mode = m;
            push_sweep(m, 1);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            for (int k = 0; k < 16; k++) begin
                int e;
                e = exp_abcd.pop_front();
                checks++;
                if (abcd_a !== 4'(e) || busy_a !== 1'b1 || done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_m%0d_step%0d: abcd=%0d busy=%b done=%b required abcd=%0d busy=1 done=0",
                             m, k, abcd_a, busy_a, done_a, e);
                end
                @(negedge clk);
            end
            r = exp_res.pop_front();
            checks++;
            if (done_a !== 1'b1 || busy_a !== 1'b0 || abcd_a !== 4'd0) begin
                errors++;
                $display("FAIL done_m%0d: done=%b busy=%b abcd=%0d required 1 0 0", m, done_a, busy_a, abcd_a);
            end
            checks++;
            if (pass_a !== r.pass) begin
                errors++;
                $display("FAIL pass_m%0d: got %b required %b", m, pass_a, r.pass);
            end
            checks++;
            if (err_a !== r.err) begin
                errors++;
                $display("FAIL err_m%0d: got %0d required %0d", m, err_a, r.err);
            end
            checks++;
            if (ffi_a !== r.ffi || ffv_a !== r.ffv) begin
                errors++;
                $display("FAIL first_fail_m%0d: got idx=%0d vld=%b required idx=%0d vld=%b",
                         m, ffi_a, ffv_a, r.ffi, r.ffv);
            end
            checks++;
            if (resp_a !== r.resp) begin
                errors++;
                $display("FAIL resp_m%0d: got %h required %h", m, resp_a, r.resp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_settle;
        res_t r;
        push_sweep(0, 3);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 48; k++) begin
            int e;
            e = exp_abcd.pop_front();
            checks++;
            if (abcd_b !== 4'(e) || busy_b !== 1'b1 || done_b !== 1'b0) begin
                errors++;
                $display("FAIL settle_step%0d: abcd=%0d busy=%b done=%b required abcd=%0d busy=1 done=0",
                         k, abcd_b, busy_b, done_b, e);
            end
            @(negedge clk);
        end
        r = exp_res.pop_front();
        checks++;
        if (done_b !== 1'b1 || pass_b !== r.pass || err_b !== r.err || resp_b !== r.resp) begin
            errors++;
            $display("FAIL settle_done: done=%b pass=%b err=%0d resp=%h required 1 %b %0d %h",
                     done_b, pass_b, err_b, resp_b, r.pass, r.err, r.resp);
        end
    endtask

    task automatic test_restart;
        res_t r;
        mode = 1;
        push_sweep(1, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int e;
            e = exp_abcd.pop_front();
            checks++;
            if (abcd_a !== 4'(e)) begin
                errors++;
                $display("FAIL restart_ignore_step%0d: abcd=%0d required %0d", k, abcd_a, e);
            end
            start_a = (k == 6);
            @(negedge clk);
        end
        start_a = 1'b0;
        r = exp_res.pop_front();
        checks++;
        if (done_a !== 1'b1 || err_a !== r.err || resp_a !== r.resp) begin
            errors++;
            $display("FAIL restart_first: done=%b err=%0d resp=%h required 1 %0d %h",
                     done_a, err_a, resp_a, r.err, r.resp);
        end
        mode = 0;
        push_sweep(0, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || err_a !== 5'd0 || ffv_a !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: done=%b busy=%b err=%0d ffv=%b required 0 1 0 0",
                     done_a, busy_a, err_a, ffv_a);
        end
        for (int k = 0; k < 16; k++) begin
            int e;
            e = exp_abcd.pop_front();
            checks++;
            if (abcd_a !== 4'(e)) begin
                errors++;
                $display("FAIL restart_sweep_step%0d: abcd=%0d required %0d", k, abcd_a, e);
            end
            @(negedge clk);
        end
        r = exp_res.pop_front();
        checks++;
        if (done_a !== 1'b1 || pass_a !== r.pass || resp_a !== r.resp) begin
            errors++;
            $display("FAIL restart_second: done=%b pass=%b resp=%h required 1 %b %h",
                     done_a, pass_a, resp_a, r.pass, r.resp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        res_t r;
        mode = 0;
        push_sweep(0, 1);
        push_sweep(0, 1);
        start_a = 1'b1;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) @(negedge clk);
            for (int k = 0; k < 16; k++) begin
                int e;
                e = exp_abcd.pop_front();
                checks++;
                if (abcd_a !== 4'(e) || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_s%0d_step%0d: abcd=%0d busy=%b required %0d 1", s, k, abcd_a, busy_a, e);
                end
                @(negedge clk);
            end
            r = exp_res.pop_front();
            checks++;
            if (done_a !== 1'b1 || pass_a !== r.pass || resp_a !== r.resp) begin
                errors++;
                $display("FAIL b2b_done_s%0d: done=%b pass=%b resp=%h required 1 %b %h",
                         s, done_a, pass_a, resp_a, r.pass, r.resp);
            end
            @(negedge clk);
            if (s == 0) begin
                // start still high: the DONE state has already been left again.
                checks++;
                if (done_a !== 1'b0 || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rearm: done=%b busy=%b required 0 1", done_a, busy_a);
                end
                start_a = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset;
        res_t r;
        mode = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (abcd_a !== 4'd5 || resp_a !== 16'h0008) begin
            errors++;
            $display("FAIL arst_pre: abcd=%0d resp=%h required 5 0008", abcd_a, resp_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || abcd_a !== 4'd0 || resp_a !== 16'h0 || err_a !== 5'd0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL arst_abort: busy=%b abcd=%0d resp=%h err=%0d done=%b required all 0",
                     busy_a, abcd_a, resp_a, err_a, done_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_sweep(0, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int e;
            e = exp_abcd.pop_front();
            checks++;
            if (abcd_a !== 4'(e)) begin
                errors++;
                $display("FAIL arst_sweep_step%0d: abcd=%0d required %0d", k, abcd_a, e);
            end
            @(negedge clk);
        end
        r = exp_res.pop_front();
        checks++;
        if (done_a !== 1'b1 || pass_a !== r.pass || err_a !== r.err || resp_a !== r.resp) begin
            errors++;
            $display("FAIL arst_clean: done=%b pass=%b err=%0d resp=%h required 1 %b %0d %h",
                     done_a, pass_a, err_a, resp_a, r.pass, r.err, r.resp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sweep_patterns();
        test_settle();
        test_restart();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
